respondedor_bus_rtc: RTL and testbench



---
 rtl/respondedor_bus_rtc.sv | 207 ++++++++++++++++++++
 tb/tb_respondedor_bus_rtc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/respondedor_bus_rtc.sv
// RTC bus responder: emulates the device end of the multiplexed RTC bus.
// Latches an address, commits writes, drives read data, and keeps BCD
// date/time counters that advance on an external 1 s tick.
module respondedor_bus_rtc #(
  parameter logic [7:0] ADDR_SEG  = 8'h21,
  parameter logic [7:0] ADDR_MIN  = 8'h22,
  parameter logic [7:0] ADDR_HORA = 8'h23,
  parameter logic [7:0] ADDR_DIA  = 8'h24,
  parameter logic [7:0] ADDR_MES  = 8'h25,
  parameter logic [7:0] ADDR_ANIO = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reg_a_d,
  input  logic       reg_cs,
  input  logic       reg_rd,
  input  logic       reg_wr,
  inout  wire  [7:0] dato,
  input  logic       in_tick_1s,
  output logic       out_escritura_hecha,
  output logic       out_error_bus
);

  typedef enum logic [1:0] {IDLE, DIR, ESC, LEC} estado_t;

  estado_t    r_estado, w_sig;
  logic       r_s_a_d, r_s_cs, r_s_rd, r_s_wr;
  logic [7:0] r_s_dato, r_addr, r_cap, r_rd_buf;
  logic [7:0] r_seg, r_min, r_hora, r_dia, r_mes, r_anio;
  logic       r_tick_pend, r_esc, r_err;

  logic       w_err, w_fin_dir, w_fin_esc, w_ent_lec, w_mapeada, w_commit, w_tick;
  logic [7:0] w_rd_val, w_dias;
  logic [7:0] w_seg_n, w_min_n, w_hora_n, w_dia_n, w_mes_n, w_anio_n;
  logic       w_c_seg, w_c_min, w_c_hora, w_c_dia, w_c_mes, w_c_anio;

  // Increment a BCD field; anything at or above its max wraps to the minimum and carries.
  function automatic logic [8:0] inc_bcd(input logic [7:0] v, input logic [7:0] vmin,
                                         input logic [7:0] vmax);
    logic [8:0] r;
    if (v >= vmax)           r = {1'b1, vmin};
    else if (v[3:0] >= 4'd9) r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     r = {1'b0, v + 8'd1};
    return r;
  endfunction

  // Register every bus pin once; all decisions below use these samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_a_d  <= 1'b1;
      r_s_cs   <= 1'b1;
      r_s_rd   <= 1'b1;
      r_s_wr   <= 1'b1;
      r_s_dato <= 8'h00;
    end else begin
      r_s_a_d  <= reg_a_d;
      r_s_cs   <= reg_cs;
      r_s_rd   <= reg_rd;
      r_s_wr   <= reg_wr;
      r_s_dato <= dato;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_estado <= IDLE;
    else       r_estado <= w_sig;
  end

  // Next state and transaction events; RD+WR low together overrides everything.
  always_comb begin
    w_sig     = r_estado;
    w_err     = 1'b0;
    w_fin_dir = 1'b0;
    w_fin_esc = 1'b0;
    w_ent_lec = 1'b0;
    if (!r_s_cs && !r_s_rd && !r_s_wr) begin
      w_err = 1'b1;
      w_sig = IDLE;
    end else begin
      case (r_estado)
        IDLE: if (!r_s_cs) begin
                if (!r_s_wr) w_sig = r_s_a_d ? ESC : DIR;
                else if (!r_s_rd && r_s_a_d) begin
                  w_sig     = LEC;
                  w_ent_lec = 1'b1;
                end
              end
        DIR:  if (r_s_cs) w_sig = IDLE;
              else if (r_s_wr) begin
                w_fin_dir = 1'b1;
                w_sig     = IDLE;
              end
        ESC:  if (r_s_cs) w_sig = IDLE;
              else if (r_s_wr) begin
                w_fin_esc = 1'b1;
                w_sig     = IDLE;
              end
        LEC:  if (r_s_cs || r_s_rd) w_sig = IDLE;
        default: w_sig = IDLE;
      endcase
    end
  end

  // Address decode for reads; unmapped addresses read as zero.
  always_comb begin
    w_mapeada = 1'b1;
    case (r_addr)
      ADDR_SEG:  w_rd_val = r_seg;
      ADDR_MIN:  w_rd_val = r_min;
      ADDR_HORA: w_rd_val = r_hora;
      ADDR_DIA:  w_rd_val = r_dia;
      ADDR_MES:  w_rd_val = r_mes;
      ADDR_ANIO: w_rd_val = r_anio;
      default: begin
        w_rd_val  = 8'h00;
        w_mapeada = 1'b0;
      end
    endcase
  end

  assign w_commit = w_fin_esc && w_mapeada;
  assign w_tick   = in_tick_1s || r_tick_pend;

  // Month length (no leap years); an invalid month behaves as a 31-day month.
  always_comb begin
    case (r_mes)
      8'h02:                      w_dias = 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: w_dias = 8'h30;
      default:                    w_dias = 8'h31;
    endcase
  end

  // Candidate next value and carry of every field.
  always_comb begin
    {w_c_seg,  w_seg_n}  = inc_bcd(r_seg,  8'h00, 8'h59);
    {w_c_min,  w_min_n}  = inc_bcd(r_min,  8'h00, 8'h59);
    {w_c_hora, w_hora_n} = inc_bcd(r_hora, 8'h00, 8'h23);
    {w_c_dia,  w_dia_n}  = inc_bcd(r_dia,  8'h01, w_dias);
    {w_c_mes,  w_mes_n}  = inc_bcd(r_mes,  8'h01, 8'h12);
    {w_c_anio, w_anio_n} = inc_bcd(r_anio, 8'h00, 8'h99);
  end

  // Address latch, write capture, read buffer and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= 8'h00;
      r_cap    <= 8'h00;
      r_rd_buf <= 8'h00;
      r_esc    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (!r_s_wr)   r_cap    <= r_s_dato;
      if (w_fin_dir) r_addr   <= r_cap;
      if (w_ent_lec) r_rd_buf <= w_rd_val;
      r_esc <= w_commit;
      r_err <= w_err;
    end
  end

  // Time registers: a write commit wins over a tick, which is deferred one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg       <= 8'h00;
      r_min       <= 8'h00;
      r_hora      <= 8'h00;
      r_dia       <= 8'h01;
      r_mes       <= 8'h01;
      r_anio      <= 8'h00;
      r_tick_pend <= 1'b0;
    end else if (w_commit) begin
      r_tick_pend <= w_tick;
      case (r_addr)
        ADDR_SEG:  r_seg  <= r_cap;
        ADDR_MIN:  r_min  <= r_cap;
        ADDR_HORA: r_hora <= r_cap;
        ADDR_DIA:  r_dia  <= r_cap;
        ADDR_MES:  r_mes  <= r_cap;
        ADDR_ANIO: r_anio <= r_cap;
        default: ;
      endcase
    end else begin
      r_tick_pend <= 1'b0;
      if (w_tick) begin
        r_seg <= w_seg_n;
        if (w_c_seg) begin
          r_min <= w_min_n;
          if (w_c_min) begin
            r_hora <= w_hora_n;
            if (w_c_hora) begin
              r_dia <= w_dia_n;
              if (w_c_dia) begin
                r_mes <= w_mes_n;
                if (w_c_mes) r_anio <= w_anio_n;
              end
            end
          end
        end
      end
    end
  end

  assign dato                = (r_estado == LEC) ? r_rd_buf : 8'hzz;
  assign out_escritura_hecha = r_esc;
  assign out_error_bus       = r_err;

endmodule

// File: tb/tb_respondedor_bus_rtc.sv
// Directed bench for respondedor_bus_rtc: a date/time model in plain integers,
// a per-cycle compare of dato and both pulse outputs, and literal pins.
module tb_respondedor_bus_rtc;

  logic clk = 1'b0;
  logic reset, reg_a_d, reg_cs, reg_rd, reg_wr, in_tick_1s;
  logic out_escritura_hecha, out_error_bus;
  // Pulled-up bus: a released bus reads 8'hFF.
  tri1 [7:0] dato;
  logic       tb_oe;
  logic [7:0] tb_dato;
  assign dato = tb_oe ? tb_dato : 8'hzz;

  respondedor_bus_rtc dut (
    .clk(clk), .reset(reset), .reg_a_d(reg_a_d), .reg_cs(reg_cs),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .dato(dato), .in_tick_1s(in_tick_1s),
    .out_escritura_hecha(out_escritura_hecha), .out_error_bus(out_error_bus)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int checks = 0, failures = 0;
  int rd_lo = -1, rd_hi = -2, exp_esc_cyc = -1, exp_err_cyc = -1;
  logic [7:0] rd_val, last_rd;
  logic [7:0] mdl [0:255];
  logic [7:0] mdl_addr;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  // Per-cycle compare of everything the responder puts on its pins.
  always @(negedge clk) begin
    if (cnt >= 2) begin
      if (cnt >= rd_lo && cnt <= rd_hi) begin
        chk("dato_read", dato, rd_val);
        if (cnt == rd_lo + 1) last_rd = dato;
      end else if (!tb_oe) chk("dato_released", dato, 8'hFF);
      chk("escritura_hecha", {7'd0, out_escritura_hecha}, {7'd0, cnt == exp_esc_cyc});
      chk("error_bus", {7'd0, out_error_bus}, {7'd0, cnt == exp_err_cyc});
    end
  end

  function automatic bit mapped(input logic [7:0] a);
    return a >= 8'h21 && a <= 8'h26;
  endfunction

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] enc(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mdl[8'h24] = 8'h01;
    mdl[8'h25] = 8'h01;
    mdl_addr   = 8'h00;
  endtask

  // One second of calendar time on integer fields.
  task automatic model_tick();
    int s, mi, h, d, mo, y, dim;
    int mdays[12];
    mdays = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    s  = dec(mdl[8'h21]); mi = dec(mdl[8'h22]); h = dec(mdl[8'h23]);
    d  = dec(mdl[8'h24]); mo = dec(mdl[8'h25]); y = dec(mdl[8'h26]);
    dim = (mo >= 1 && mo <= 12) ? mdays[mo-1] : 31;
    if (s >= 59) begin
      mdl[8'h21] = enc(0);
      if (mi >= 59) begin
        mdl[8'h22] = enc(0);
        if (h >= 23) begin
          mdl[8'h23] = enc(0);
          if (d >= dim) begin
            mdl[8'h24] = enc(1);
            if (mo >= 12) begin
              mdl[8'h25] = enc(1);
              mdl[8'h26] = (y >= 99) ? enc(0) : enc(y + 1);
            end else mdl[8'h25] = enc(mo + 1);
          end else mdl[8'h24] = enc(d + 1);
        end else mdl[8'h23] = enc(h + 1);
      end else mdl[8'h22] = enc(mi + 1);
    end else mdl[8'h21] = enc(s + 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    reg_cs = 1'b1; reg_rd = 1'b1; reg_wr = 1'b1; reg_a_d = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic wr_addr(input logic [7:0] a);
    step(); reg_cs = 1'b0; reg_a_d = 1'b0; reg_wr = 1'b0; tb_oe = 1'b1; tb_dato = a;
    step(); reg_wr = 1'b1;
    step(); bus_idle();
    mdl_addr = a;
  endtask

  // Data write; with tk set, a tick is high at the commit edge and the one after.
  task automatic wr_data(input logic [7:0] d, input bit tk);
    step(); reg_cs = 1'b0; reg_a_d = 1'b1; reg_wr = 1'b0; tb_oe = 1'b1; tb_dato = d;
    step(); reg_wr = 1'b1;
    if (mapped(mdl_addr)) exp_esc_cyc = cnt + 2;
    step(); bus_idle(); in_tick_1s = tk;
    step(); in_tick_1s = tk;
    step(); in_tick_1s = 1'b0;
    if (mapped(mdl_addr)) mdl[mdl_addr] = d;
    if (tk) model_tick();
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [7:0] d);
    wr_addr(a);
    wr_data(d, 1'b0);
  endtask

  // Read with RD held low for 'hold' cycles; tk ticks once mid-strobe.
  task automatic rd_reg(input logic [7:0] a, input int hold, input bit tk);
    wr_addr(a);
    step(); reg_cs = 1'b0; reg_a_d = 1'b1; reg_rd = 1'b0;
    rd_val = mapped(a) ? mdl[a] : 8'h00;
    rd_lo = cnt + 2; rd_hi = 1000000;
    for (int i = 1; i < hold; i++) begin
      step(); in_tick_1s = tk && (i == 2);
    end
    step(); bus_idle(); in_tick_1s = 1'b0; rd_hi = cnt + 1;
    repeat (3) step();
    if (tk) model_tick();
  endtask

  task automatic tick();
    step(); in_tick_1s = 1'b1;
    step(); in_tick_1s = 1'b0;
    model_tick();
    step();
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1; in_tick_1s = 1'b0; tb_dato = 8'h00; last_rd = 8'h00; rd_val = 8'h00;
    bus_idle();
    model_reset();
    repeat (4) step();
    reset = 1'b0;
    repeat (2) step();

    // Reset state and basic write/read
    rd_reg(8'h24, 4, 1'b0); chk("reset_dia", last_rd, 8'h01);
    rd_reg(8'h21, 4, 1'b0); chk("reset_seg", last_rd, 8'h00);
    set_reg(8'h21, 8'h45);
    rd_reg(8'h21, 4, 1'b0); chk("t1_read_seg", last_rd, 8'h45);

    // Full ripple at end of February, year held at 99
    set_reg(8'h23, 8'h23); set_reg(8'h22, 8'h59); set_reg(8'h21, 8'h59);
    set_reg(8'h24, 8'h28); set_reg(8'h25, 8'h02); set_reg(8'h26, 8'h99);
    tick();
    rd_reg(8'h21, 4, 1'b0); chk("t2_seg", last_rd, 8'h00);
    rd_reg(8'h22, 4, 1'b0); chk("t2_min", last_rd, 8'h00);
    rd_reg(8'h23, 4, 1'b0); chk("t2_hora", last_rd, 8'h00);
    rd_reg(8'h24, 4, 1'b0); chk("t2_dia", last_rd, 8'h01);
    rd_reg(8'h25, 4, 1'b0); chk("t2_mes", last_rd, 8'h03);
    rd_reg(8'h26, 4, 1'b0); chk("t2_anio", last_rd, 8'h99);

    // New Year rollover, year 99 -> 00
    set_reg(8'h25, 8'h12); set_reg(8'h24, 8'h31); set_reg(8'h23, 8'h23);
    set_reg(8'h22, 8'h59); set_reg(8'h21, 8'h59);
    tick();
    rd_reg(8'h25, 4, 1'b0); chk("t2b_mes", last_rd, 8'h01);
    rd_reg(8'h24, 4, 1'b0); chk("t2b_dia", last_rd, 8'h01);
    rd_reg(8'h26, 4, 1'b0); chk("t2b_anio", last_rd, 8'h00);

    // Out-of-range seconds wrap and carry
    set_reg(8'h21, 8'h7A); set_reg(8'h22, 8'h10);
    tick();
    rd_reg(8'h21, 4, 1'b0); chk("oor_seg", last_rd, 8'h00);
    rd_reg(8'h22, 4, 1'b0); chk("oor_min", last_rd, 8'h11);

    // Tick coincident with commit, plus a merged second tick
    wr_addr(8'h21);
    wr_data(8'h10, 1'b1);
    chk("t3_model_seg", mdl[8'h21], 8'h11);
    rd_reg(8'h21, 4, 1'b0); chk("t3_seg", last_rd, 8'h11);

    // Tick in the middle of a read strobe
    set_reg(8'h21, 8'h59);
    rd_reg(8'h21, 6, 1'b1); chk("t4_hold", last_rd, 8'h59);
    rd_reg(8'h21, 4, 1'b0); chk("t4_after", last_rd, 8'h00);
    rd_reg(8'h22, 4, 1'b0); chk("t4_min", last_rd, 8'h12);

    // RD and WR low together: error pulse, no drive, nothing changes
    step(); reg_cs = 1'b0; reg_a_d = 1'b1; reg_rd = 1'b0; reg_wr = 1'b0;
    exp_err_cyc = cnt + 2;
    step(); bus_idle();
    repeat (3) step();
    rd_reg(8'h21, 4, 1'b0); chk("t5_seg", last_rd, 8'h00);
    // Unmapped address: no pulse, reads zero
    wr_addr(8'h55);
    wr_data(8'hAA, 1'b0);
    rd_reg(8'h55, 4, 1'b0); chk("t5_unmapped", last_rd, 8'h00);

    // Reset in the middle of a read
    set_reg(8'h21, 8'h33);
    wr_addr(8'h21);
    step(); reg_cs = 1'b0; reg_a_d = 1'b1; reg_rd = 1'b0;
    rd_val = mdl[8'h21]; rd_lo = cnt + 2; rd_hi = 1000000;
    repeat (3) step();
    reset = 1'b1; rd_hi = cnt;
    step(); bus_idle();
    step(); reset = 1'b0; model_reset();
    repeat (2) step();
    chk("t6_read_before_reset", last_rd, 8'h33);
    rd_reg(8'h21, 4, 1'b0); chk("t6_seg", last_rd, 8'h00);
    rd_reg(8'h24, 4, 1'b0); chk("t6_dia", last_rd, 8'h01);
    rd_reg(8'h25, 4, 1'b0); chk("t6_mes", last_rd, 8'h01);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
